// File: rtl/lock_uart_tx_if.sv
// Handshake and serial-line bundle between the lock core and its reporting transmitter.
// The master drives the request side, and the transmitter (slave) drives the line and status.
interface lock_uart_tx_if;
    logic        start;
    logic [23:0] digits;
    logic [1:0]  mode;
    logic        txd;
    logic        busy;
    logic        done;

    modport master (output start, digits, mode, input txd, busy, done);
    modport slave  (input start, digits, mode, output txd, busy, done);
endinterface

// File: rtl/lock_uart_tx.sv
// 8N1 transmitter that reports the latched lock code and mode as a 9-byte ASCII frame:
// mode char, six hex digits (digit5 first), CR, LF.
module lock_uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic         clk,
    input  logic         rst,
    lock_uart_tx_if.slave bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [3:0]          byte_q, byte_d;
    logic [7:0]          shift_q, shift_d;
    logic [23:0]         digits_q, digits_d;
    logic [1:0]          mode_q, mode_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [23:0] dg,
                                              input logic [1:0]  md);
        logic [7:0] c;
        case (idx)
            4'd0: begin
                case (md)
                    2'b00:   c = 8'h50;
                    2'b01:   c = 8'h4C;
                    2'b10:   c = 8'h58;
                    default: c = 8'h55;
                endcase
            end
            4'd1:    c = hex_char(dg[23:20]);
            4'd2:    c = hex_char(dg[19:16]);
            4'd3:    c = hex_char(dg[15:12]);
            4'd4:    c = hex_char(dg[11:8]);
            4'd5:    c = hex_char(dg[7:4]);
            4'd6:    c = hex_char(dg[3:0]);
            4'd7:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            digits_q <= '0;
            mode_q   <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            digits_q <= digits_d;
            mode_q   <= mode_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        digits_d = digits_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = START;
                    digits_d = bus.digits;
                    mode_d   = bus.mode;
                    byte_d   = 4'd0;
                    baud_d   = '0;
                    bit_d    = 3'd0;
                    shift_d  = frame_byte(4'd0, bus.digits, bus.mode);
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    // Next byte starts straight away; no idle gap inside a frame.
                    if (byte_q < 4'd8) begin
                        byte_d  = byte_q + 4'd1;
                        shift_d = frame_byte(byte_q + 4'd1, digits_q, mode_q);
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it aligns with the state change.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_lock_uart_tx.sv
// Bench for lock_uart_tx: a line receiver decodes bytes and checks them against a model-fed queue.
module tb_lock_uart_tx;

    localparam int C = 4;

    logic clk;
    logic rst;
    lock_uart_tx_if u_if ();

    lock_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_err;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] d, input logic [1:0] m);
        logic [7:0] c;
        logic [3:0] nib;
        case (m)
            2'b00:   c = "P";
            2'b01:   c = "L";
            2'b10:   c = "X";
            default: c = "U";
        endcase
        exp_q.push_back(c);
        for (int i = 5; i >= 0; i--) begin
            nib = d[i*4 +: 4];
            if (nib < 4'd10) exp_q.push_back(8'h30 + {4'h0, nib});
            else             exp_q.push_back(8'h41 + {4'h0, nib} - 8'd10);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Line receiver: each bit must hold one level for all C samples.
    int         rx_cyc;
    int         rx_bi;
    int         rx_ph;
    logic       rx_act;
    logic       rx_bad;
    logic [7:0] rx_b;
    logic [7:0] rx_e;

    initial begin
        rx_act = 1'b0;
        rx_cyc = 0;
        rx_bad = 1'b0;
        rx_b   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (u_if.txd == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cyc = 1;
                    rx_bad = 1'b0;
                    rx_b   = 8'h00;
                end
            end else begin
                rx_bi = rx_cyc / C;
                rx_ph = rx_cyc % C;
                if (rx_bi == 0) begin
                    if (u_if.txd !== 1'b0) rx_bad = 1'b1;
                end else if (rx_bi <= 8) begin
                    if (rx_ph == 0) rx_b[rx_bi-1] = u_if.txd;
                    else if (u_if.txd !== rx_b[rx_bi-1]) rx_bad = 1'b1;
                end else begin
                    if (u_if.txd !== 1'b1) rx_bad = 1'b1;
                end
                if (rx_cyc == 10*C - 1) begin
                    chk("bit_timing", {31'd0, rx_bad}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, rx_b}, 32'h100);
                    end else begin
                        rx_e = exp_q.pop_front();
                        chk("rx_byte", {24'd0, rx_b}, {24'd0, rx_e});
                    end
                    rx_act = 1'b0;
                end
                rx_cyc++;
            end
        end
    end

    task automatic send(input logic [23:0] d, input logic [1:0] m);
        @(negedge clk);
        u_if.digits = d;
        u_if.mode   = m;
        u_if.start  = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!u_if.done && cyc < 3000);
    endtask

    int   cyc;
    logic flag;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        u_if.start  = 1'b0;
        u_if.digits = 24'h0;
        u_if.mode   = 2'b00;

        // Reset values
        repeat (5) begin
            @(negedge clk);
            chk("rst_txd",  {31'd0, u_if.txd},  32'd1);
            chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
            chk("rst_done", {31'd0, u_if.done}, 32'd0);
        end
        rst = 1'b1;
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (u_if.txd !== 1'b1 || u_if.busy !== 1'b0) flag = 1'b0;
        end
        chk("idle_txd_high", {31'd0, flag}, 32'd1);

        // Nominal frame
        push_frame(24'h9A0F31, 2'b01);
        send(24'h9A0F31, 2'b01);
        chk("first_start_bit", {30'd0, u_if.txd, u_if.busy}, 32'b01);
        wait_done(cyc);
        chk("frame_latency", cyc, 90*C);
        chk("done_busy_low", {31'd0, u_if.busy}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);
        @(posedge clk);
        #1 chk("done_one_cycle", {31'd0, u_if.done}, 32'd0);

        // Latch and ignore, then back-to-back from a held start
        push_frame(24'h123456, 2'b11);
        @(negedge clk);
        u_if.digits = 24'h123456;
        u_if.mode   = 2'b11;
        u_if.start  = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 50) begin
                u_if.digits = 24'hFFFFFF;
                u_if.mode   = 2'b10;
            end
        end while (!u_if.done && cyc < 3000);
        chk("latch_latency", cyc, 90*C);
        chk("latch_done_busy", {31'd0, u_if.busy}, 32'd0);
        chk("latch_sb_drained", exp_q.size(), 32'd0);
        push_frame(24'hFFFFFF, 2'b10);
        @(posedge clk);
        #1 u_if.start = 1'b0;
        chk("b2b_txd", {31'd0, u_if.txd}, 32'd0);
        chk("b2b_busy", {31'd0, u_if.busy}, 32'd1);
        wait_done(cyc);
        chk("b2b_latency", cyc, 90*C);
        chk("b2b_sb_drained", exp_q.size(), 32'd0);
        flag = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (u_if.busy !== 1'b0) flag = 1'b0;
        end
        chk("single_frame_per_start", {31'd0, flag}, 32'd1);

        // Reset mid-frame
        push_frame(24'h777777, 2'b00);
        send(24'h777777, 2'b00);
        repeat (99) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_txd",  {31'd0, u_if.txd},  32'd1);
        chk("async_rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("async_rst_done", {31'd0, u_if.done}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        flag = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.txd !== 1'b1) flag = 1'b0;
        end
        chk("post_rst_quiet", {31'd0, flag}, 32'd1);
        push_frame(24'hBEEF42, 2'b01);
        send(24'hBEEF42, 2'b01);
        wait_done(cyc);
        chk("post_rst_latency", cyc, 90*C);
        chk("post_rst_sb_drained", exp_q.size(), 32'd0);

        // Mode coverage
        push_frame(24'h0000A0, 2'b00);
        send(24'h0000A0, 2'b00);
        wait_done(cyc);
        chk("mode00_latency", cyc, 90*C);
        push_frame(24'h0000A0, 2'b10);
        send(24'h0000A0, 2'b10);
        wait_done(cyc);
        chk("mode10_latency", cyc, 90*C);
        chk("mode_sb_drained", exp_q.size(), 32'd0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
